// File: rtl/calc_alu_sequencer_if.sv
// Write/result bus between the calculator front end (master) and the
// arithmetic back end calc_alu_sequencer (slave).
interface calc_alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             WE;
  logic [32:0]      address;
  logic [WIDTH-1:0] wdata;
  logic             leaResult;
  logic [WIDTH-1:0] numAGuardar;
  logic             result_valid;
  logic             busy;
  logic [1:0]       status;

  modport master (
    output WE, address, wdata, leaResult,
    input  numAGuardar, result_valid, busy, status
  );

  modport slave (
    input  WE, address, wdata, leaResult,
    output numAGuardar, result_valid, busy, status
  );
endinterface

// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer: collects operand A, operator and operand B from the
// front-end write bus, executes add/sub in one cycle and mul/div iteratively,
// and returns the result under a valid/read handshake with A-chaining.
// Optional feature macro: CALC_DIV_EN builds the restoring divider (opcode 4'hD).
module calc_alu_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic                  CLK_100MHZ,
  input  logic                  reset,
  calc_alu_sequencer_if.slave   bus
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HAVE_A,
    S_HAVE_OP,
    S_EXEC,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_DIV0    = 2'd1;
  localparam logic [1:0] ST_ILLEGAL = 2'd2;
  localparam logic [1:0] ST_SEQ     = 2'd3;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // operand A; multiplicand / dividend-quotient while iterating
  logic [WIDTH-1:0] b_q, b_d;       // operand B; multiplier shifts right while iterating
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator or partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       status_q, status_d;

  logic             wr_a, wr_op, wr_b;
  logic [3:0]       wr_code;
  logic             op_legal;
  logic             last_iter;
  logic             div_zero;
  logic             exec_done;
  logic [WIDTH-1:0] mul_acc;
  logic             unused_addr;

  // Only the two slot bits of the address are decoded.
  assign unused_addr = ^bus.address[32:2];

  assign wr_a    = bus.WE && (bus.address[1:0] == 2'd0);
  assign wr_op   = bus.WE && (bus.address[1:0] == 2'd1);
  assign wr_b    = bus.WE && (bus.address[1:0] == 2'd2);
  assign wr_code = bus.wdata[3:0];

`ifdef CALC_DIV_EN
  assign op_legal = wr_code inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  assign div_zero = (op_q == OP_DIV) && (b_q == '0);
`else
  assign op_legal = wr_code inside {OP_ADD, OP_SUB, OP_MUL};
  assign div_zero = 1'b0;
`endif

  assign last_iter = (cnt_q == CNT_W'(ITER - 1));
  assign exec_done = (op_q == OP_ADD) || (op_q == OP_SUB) || div_zero || last_iter;

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  assign mul_acc = acc_q + (b_q[0] ? a_q : '0);

`ifdef CALC_DIV_EN
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring-division step: shift the next dividend bit into the
  // remainder, keep the trial subtraction only if it did not borrow.
  assign rem_shift = {acc_q, a_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, b_q};
  assign q_bit     = ~rem_diff[WIDTH];
  assign rem_next  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_next  = {a_q[WIDTH-2:0], q_bit};
`endif

  // State register with synchronous active-low reset.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK_100MHZ) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: sequence the operand/operator/execute/result phases.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (wr_a) state_d = S_HAVE_A;
      S_HAVE_A:  if (wr_op && op_legal) state_d = S_HAVE_OP;
      S_HAVE_OP: begin
        if (wr_a)      state_d = S_HAVE_A;
        else if (wr_b) state_d = S_EXEC;
      end
      S_EXEC:    if (exec_done) state_d = S_DONE;
      S_DONE: begin
        if (wr_a)               state_d = S_HAVE_A;
        else if (wr_op)         state_d = op_legal ? S_HAVE_OP : S_HAVE_A;
        else if (bus.leaResult) state_d = S_HAVE_A;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand capture, iteration steps, result and status.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_a) begin
          a_d      = bus.wdata;
          status_d = ST_OK;
        end else if (wr_op || wr_b) begin
          status_d = ST_SEQ;
        end
      end
      S_HAVE_A: begin
        if (wr_a) begin
          a_d = bus.wdata;
        end else if (wr_op) begin
          if (op_legal) op_d     = wr_code;
          else          status_d = ST_ILLEGAL;
        end else if (wr_b) begin
          status_d = ST_SEQ;
        end
      end
      S_HAVE_OP: begin
        if (wr_a) begin
          a_d = bus.wdata;
        end else if (wr_op) begin
          if (op_legal) op_d     = wr_code;
          else          status_d = ST_ILLEGAL;
        end else if (wr_b) begin
          b_d   = bus.wdata;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (exec_done) status_d = div_zero ? ST_DIV0 : ST_OK;
        case (op_q)
          OP_ADD: res_d = a_q + b_q;
          OP_SUB: res_d = a_q - b_q;
          OP_MUL: begin
            acc_d = mul_acc;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            if (last_iter) res_d = mul_acc;
          end
`ifdef CALC_DIV_EN
          OP_DIV: begin
            if (div_zero) begin
              res_d = '1;
            end else begin
              acc_d = rem_next;
              a_d   = quo_next;
              if (last_iter) res_d = quo_next;
            end
          end
`endif
          default: ;
        endcase
      end
      S_DONE: begin
        if (wr_a) begin
          a_d      = bus.wdata;
          status_d = ST_OK;
        end else if (wr_op) begin
          a_d = res_q;
          if (op_legal) op_d     = wr_code;
          else          status_d = ST_ILLEGAL;
        end else if (bus.leaResult) begin
          a_d = res_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset also aborts any in-flight iteration.
  always_ff @(posedge CLK_100MHZ) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      status_q <= ST_OK;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      status_q <= status_d;
    end
  end

  // Outputs: valid while a result waits in DONE, busy while executing.
  always_comb begin
    bus.numAGuardar  = res_q;
    bus.result_valid = (state_q == S_DONE);
    bus.busy         = (state_q == S_EXEC);
    bus.status       = status_q;
  end

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Bench for calc_alu_sequencer: a transaction-level reference model tracks the
// expected outputs from the operation rules, a compare process checks every
// cycle, directed scenarios pin literal results, then random traffic follows.
module tb_calc_alu_sequencer;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  calc_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  calc_alu_sequencer #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .CLK_100MHZ (clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_A, P_OP, P_EXEC, P_DONE} phase_e;

  phase_e      m_phase  = P_IDLE;
  logic [31:0] m_a      = '0;
  logic [31:0] m_res    = '0;
  logic [31:0] m_pend   = '0;
  logic [3:0]  m_op     = '0;
  logic [1:0]  m_status = '0;
  logic [1:0]  m_pend_st = '0;
  int          m_left   = 0;

  function automatic bit legal(input logic [3:0] c);
`ifdef CALC_DIV_EN
    return c inside {4'hA, 4'hB, 4'hC, 4'hD};
`else
    return c inside {4'hA, 4'hB, 4'hC};
`endif
  endfunction

  task automatic model_step();
    logic [1:0]  slot;
    logic        wr;
    logic [31:0] d;
    slot = bus.address[1:0];
    wr   = bus.WE;
    d    = bus.wdata;
    if (!reset) begin
      m_phase = P_IDLE; m_a = '0; m_op = '0; m_res = '0; m_status = 2'd0; m_left = 0;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        if (wr && slot == 2'd0) begin m_a = d; m_status = 2'd0; m_phase = P_A; end
        else if (wr && (slot == 2'd1 || slot == 2'd2)) m_status = 2'd3;
      end
      P_A: begin
        if (wr && slot == 2'd0) m_a = d;
        else if (wr && slot == 2'd1) begin
          if (legal(d[3:0])) begin m_op = d[3:0]; m_phase = P_OP; end
          else m_status = 2'd2;
        end else if (wr && slot == 2'd2) m_status = 2'd3;
      end
      P_OP: begin
        if (wr && slot == 2'd0) begin m_a = d; m_phase = P_A; end
        else if (wr && slot == 2'd1) begin
          if (legal(d[3:0])) m_op = d[3:0];
          else m_status = 2'd2;
        end else if (wr && slot == 2'd2) begin
          m_phase   = P_EXEC;
          m_pend_st = 2'd0;
          m_left    = ITER;
          case (m_op)
            4'hA:    begin m_pend = m_a + d; m_left = 1; end
            4'hB:    begin m_pend = m_a - d; m_left = 1; end
            4'hC:    m_pend = m_a * d;
            default: begin
              if (d == 0) begin m_pend = '1; m_pend_st = 2'd1; m_left = 1; end
              else m_pend = m_a / d;
            end
          endcase
        end
      end
      P_EXEC: begin
        m_left--;
        if (m_left == 0) begin m_res = m_pend; m_status = m_pend_st; m_phase = P_DONE; end
      end
      default: begin // P_DONE
        if (wr && slot == 2'd0) begin m_a = d; m_status = 2'd0; m_phase = P_A; end
        else if (wr && slot == 2'd1) begin
          m_a = m_res;
          if (legal(d[3:0])) begin m_op = d[3:0]; m_phase = P_OP; end
          else begin m_status = 2'd2; m_phase = P_A; end
        end else if (bus.leaResult) begin m_a = m_res; m_phase = P_A; end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    check("result_valid", 32'(bus.result_valid), 32'(m_phase == P_DONE));
    check("busy",         32'(bus.busy),         32'(m_phase == P_EXEC));
    check("status",       32'(bus.status),       32'(m_status));
    check("numAGuardar",  bus.numAGuardar,       m_res);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed helpers (entered and left at a negedge) ----------------
  task automatic wr(input logic [1:0] slot, input logic [31:0] d);
    bus.WE = 1'b1; bus.address = {31'd0, slot}; bus.wdata = d;
    @(negedge clk);
    bus.WE = 1'b0; bus.address = '0; bus.wdata = '0;
  endtask

  task automatic read_pulse();
    bus.leaResult = 1'b1;
    @(negedge clk);
    bus.leaResult = 1'b0;
  endtask

  task automatic wait_done(output int busy_n);
    busy_n = 0;
    for (int i = 0; i < 200 && !bus.result_valid; i++) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
    end
    if (!bus.result_valid) check("timeout waiting for result_valid", 32'd0, 32'd1);
  endtask

  initial begin
    int bn;
    bus.WE = 1'b0; bus.address = '0; bus.wdata = '0; bus.leaResult = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset numAGuardar", bus.numAGuardar, 32'd0);
    check("reset result_valid", 32'(bus.result_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset status", 32'(bus.status), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Slot-2 write in IDLE: sequence error, no result.
    wr(2'd2, 32'd5);
    check("idle slot2 status", 32'(bus.status), 32'd3);
    check("idle slot2 valid", 32'(bus.result_valid), 32'd0);

    // 7 - 9 wraps.
    wr(2'd0, 32'd7); wr(2'd1, 32'hB); wr(2'd2, 32'd9);
    check("sub busy after B", 32'(bus.busy), 32'd1);
    wait_done(bn);
    check("sub busy cycles", 32'(bn), 32'd1);
    check("sub result", bus.numAGuardar, 32'hFFFF_FFFE);
    check("sub status", 32'(bus.status), 32'd0);

    // 12345 * 678, then chain + 10.
    wr(2'd0, 32'd12345); wr(2'd1, 32'hC); wr(2'd2, 32'd678);
    wait_done(bn);
    check("mul busy cycles", 32'(bn), 32'd32);
    check("mul result", bus.numAGuardar, 32'd8369910);
    read_pulse();
    check("read clears valid", 32'(bus.result_valid), 32'd0);
    check("result held after read", bus.numAGuardar, 32'd8369910);
    wr(2'd1, 32'hA); wr(2'd2, 32'd10);
    wait_done(bn);
    check("chain result", bus.numAGuardar, 32'd8369920);

`ifdef CALC_DIV_EN
    wr(2'd0, 32'd100); wr(2'd1, 32'hD); wr(2'd2, 32'd7);
    wait_done(bn);
    check("div busy cycles", 32'(bn), 32'd32);
    check("div result", bus.numAGuardar, 32'd14);
    wr(2'd0, 32'd5); wr(2'd1, 32'hD); wr(2'd2, 32'd0);
    wait_done(bn);
    check("div0 busy cycles", 32'(bn), 32'd1);
    check("div0 result", bus.numAGuardar, 32'hFFFF_FFFF);
    check("div0 status", 32'(bus.status), 32'd1);
`else
    wr(2'd0, 32'd5); wr(2'd1, 32'hD);
    check("div disabled status", 32'(bus.status), 32'd2);
    check("div disabled no valid", 32'(bus.result_valid), 32'd0);
    wr(2'd1, 32'hA); wr(2'd2, 32'd1);
    wait_done(bn);
    check("div disabled kept A", bus.numAGuardar, 32'd6);
`endif

    // Slot-0 write during EXEC is ignored.
    wr(2'd0, 32'd6); wr(2'd1, 32'hC); wr(2'd2, 32'd7);
    repeat (3) @(negedge clk);
    wr(2'd0, 32'd99);
    wait_done(bn);
    check("write during exec ignored", bus.numAGuardar, 32'd42);

    // Reset mid-multiply aborts.
    wr(2'd0, 32'd1000); wr(2'd1, 32'hC); wr(2'd2, 32'd1000);
    repeat (15) @(negedge clk);
    check("mul still busy before abort", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    begin
      int seen_valid;
      seen_valid = 0;
      for (int i = 0; i < 40; i++) begin
        if (bus.result_valid || bus.busy) seen_valid++;
        @(negedge clk);
      end
      check("abort: no valid/busy after reset", 32'(seen_valid), 32'd0);
    end
    check("abort: result cleared", bus.numAGuardar, 32'd0);

    // In DONE, read and slot-0 write together: the write wins.
    wr(2'd0, 32'd2); wr(2'd1, 32'hA); wr(2'd2, 32'd2);
    wait_done(bn);
    check("2+2", bus.numAGuardar, 32'd4);
    bus.WE = 1'b1; bus.address = '0; bus.wdata = 32'd3; bus.leaResult = 1'b1;
    @(negedge clk);
    bus.WE = 1'b0; bus.wdata = '0; bus.leaResult = 1'b0;
    check("write+read clears valid", 32'(bus.result_valid), 32'd0);
    wr(2'd1, 32'hA); wr(2'd2, 32'd0);
    wait_done(bn);
    check("write wins over read (A=3)", bus.numAGuardar, 32'd3);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int sel;
      reset         = ($urandom_range(0, 999) != 0);
      bus.WE        = ($urandom_range(0, 2) == 0);
      bus.address   = {1'($urandom), $urandom};
      sel           = $urandom_range(0, 3);
      case (sel)
        0:       bus.wdata = $urandom_range(8, 15);
        1:       bus.wdata = 32'd0;
        2:       bus.wdata = $urandom_range(0, 300);
        default: bus.wdata = $urandom;
      endcase
      bus.leaResult = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    reset = 1'b1; bus.WE = 1'b0; bus.address = '0; bus.wdata = '0; bus.leaResult = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
